// File: rtl/seq_gen_sync_tx.sv
// ============================================================================
// Module   : seq_gen_sync_tx
// Brief    : Serial frame transmitter: SYNC_PAT preamble, MSB-first payload,
//            optional even parity (SEQ_GEN_PARITY_EN), then GAP_BITS idle zeros.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module seq_gen_sync_tx #(
    parameter int                DATA_W   = 8,
    parameter int                SYNC_W   = 4,
    parameter logic [SYNC_W-1:0] SYNC_PAT = 4'b1011,
    parameter int                GAP_BITS = 1,
    parameter int                CNT_W    = 16
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [DATA_W-1:0] in_data,
    input  logic              in_valid,
    output logic              in_ready,
    output logic              out_bit,
    output logic              out_valid,
    output logic              sync_start,
    output logic              busy,
    output logic [CNT_W-1:0]  frame_cnt
);

`ifdef SEQ_GEN_PARITY_EN
    localparam int PAR_W = 1;
`else
    localparam int PAR_W = 0;
`endif
    localparam int FRAME_W  = SYNC_W + DATA_W + PAR_W;
    localparam int MAX_LEN  = (SYNC_W > DATA_W) ? ((SYNC_W > GAP_BITS) ? SYNC_W : GAP_BITS)
                                                : ((DATA_W > GAP_BITS) ? DATA_W : GAP_BITS);
    localparam int CW       = (MAX_LEN < 2) ? 1 : $clog2(MAX_LEN);
    localparam logic [CW-1:0] C_SYNC_LAST = CW'(SYNC_W - 1);
    localparam logic [CW-1:0] C_DATA_LAST = CW'(DATA_W - 1);
    localparam logic [CW-1:0] C_GAP_LAST  = CW'((GAP_BITS > 0) ? GAP_BITS - 1 : 0);

    typedef enum logic [2:0] {
        IDLE = 3'd0,
        SYNC = 3'd1,
        DATA = 3'd2,
`ifdef SEQ_GEN_PARITY_EN
        PAR  = 3'd3,
`endif
        GAP  = 3'd4
    } state_t;

    state_t               r_state;
    state_t               w_state_nxt;
    logic [CW-1:0]        r_cnt;
    logic [CW-1:0]        w_cnt_nxt;
    logic [FRAME_W-1:0]   r_shreg;
    logic                 r_out_valid;
    logic                 r_sync_start;
    logic                 r_busy;
    logic [CNT_W-1:0]     r_frame_cnt;
    logic                 w_accept;
    logic                 w_last_bit;
    logic [FRAME_W-1:0]   w_frame;

    assign in_ready   = (r_state == IDLE);
    assign w_accept   = in_valid && in_ready;
    // The shift register doubles as the captured word; its MSB is the line.
`ifdef SEQ_GEN_PARITY_EN
    assign w_frame    = {SYNC_PAT, in_data, ^in_data};
    assign w_last_bit = (r_state == PAR);
`else
    assign w_frame    = {SYNC_PAT, in_data};
    assign w_last_bit = (r_state == DATA) && (r_cnt == C_DATA_LAST);
`endif

    assign out_bit    = r_shreg[FRAME_W-1];
    assign out_valid  = r_out_valid;
    assign sync_start = r_sync_start;
    assign busy       = r_busy;
    assign frame_cnt  = r_frame_cnt;

    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        case (r_state)
            IDLE: begin
                if (w_accept) begin
                    w_state_nxt = SYNC;
                    w_cnt_nxt   = '0;
                end
            end
            SYNC: begin
                if (r_cnt == C_SYNC_LAST) begin
                    w_state_nxt = DATA;
                    w_cnt_nxt   = '0;
                end else begin
                    w_cnt_nxt   = r_cnt + 1'b1;
                end
            end
            DATA: begin
                if (r_cnt == C_DATA_LAST) begin
`ifdef SEQ_GEN_PARITY_EN
                    w_state_nxt = PAR;
`else
                    w_state_nxt = (GAP_BITS > 0) ? GAP : IDLE;
`endif
                    w_cnt_nxt   = '0;
                end else begin
                    w_cnt_nxt   = r_cnt + 1'b1;
                end
            end
`ifdef SEQ_GEN_PARITY_EN
            PAR: begin
                w_state_nxt = (GAP_BITS > 0) ? GAP : IDLE;
                w_cnt_nxt   = '0;
            end
`endif
            GAP: begin
                if (r_cnt == C_GAP_LAST) begin
                    w_state_nxt = IDLE;
                    w_cnt_nxt   = '0;
                end else begin
                    w_cnt_nxt   = r_cnt + 1'b1;
                end
            end
            default: begin
                w_state_nxt = IDLE;
                w_cnt_nxt   = '0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state      <= IDLE;
            r_cnt        <= '0;
            r_shreg      <= '0;
            r_out_valid  <= 1'b0;
            r_sync_start <= 1'b0;
            r_busy       <= 1'b0;
            r_frame_cnt  <= '0;
        end else begin
            r_state      <= w_state_nxt;
            r_cnt        <= w_cnt_nxt;
            r_shreg      <= w_accept ? w_frame : {r_shreg[FRAME_W-2:0], 1'b0};
            r_out_valid  <= (w_state_nxt == SYNC) || (w_state_nxt == DATA)
`ifdef SEQ_GEN_PARITY_EN
                            || (w_state_nxt == PAR)
`endif
                            ;
            r_sync_start <= w_accept;
            r_busy       <= (w_state_nxt != IDLE);
            if (w_last_bit) begin
                r_frame_cnt <= r_frame_cnt + 1'b1;
            end
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_seq_gen_sync_tx.sv
// ============================================================================
// Module   : tb_seq_gen_sync_tx
// Brief    : Randomized bench for seq_gen_sync_tx against a queue-based
//            line model; a second instance uses a 2-bit frame counter.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_seq_gen_sync_tx;

    localparam int          DATA_W   = 8;
    localparam int          SYNC_W   = 4;
    localparam logic [3:0]  SYNC_PAT = 4'b1011;
    localparam int          GAP_BITS = 1;
    localparam int          CNT_W    = 16;

    logic              clk = 1'b0;
    logic              reset = 1'b0;
    logic [DATA_W-1:0] in_data = '0;
    logic              in_valid = 1'b0;
    logic              in_ready, out_bit, out_valid, sync_start, busy;
    logic [CNT_W-1:0]  frame_cnt;
    logic              in_ready2, out_bit2, out_valid2, sync_start2, busy2;
    logic [1:0]        frame_cnt2;

    always #5 clk = ~clk;

    seq_gen_sync_tx #(.DATA_W(DATA_W), .SYNC_W(SYNC_W), .SYNC_PAT(SYNC_PAT),
                      .GAP_BITS(GAP_BITS), .CNT_W(CNT_W)) u_dut (
        .clk(clk), .reset(reset), .in_data(in_data), .in_valid(in_valid),
        .in_ready(in_ready), .out_bit(out_bit), .out_valid(out_valid),
        .sync_start(sync_start), .busy(busy), .frame_cnt(frame_cnt)
    );

    seq_gen_sync_tx #(.DATA_W(DATA_W), .SYNC_W(SYNC_W), .SYNC_PAT(SYNC_PAT),
                      .GAP_BITS(GAP_BITS), .CNT_W(2)) u_dut_c2 (
        .clk(clk), .reset(reset), .in_data(in_data), .in_valid(in_valid),
        .in_ready(in_ready2), .out_bit(out_bit2), .out_valid(out_valid2),
        .sync_start(sync_start2), .busy(busy2), .frame_cnt(frame_cnt2)
    );

    // One entry per future line cycle: what the transmitter should show then.
    typedef struct packed {
        logic b;
        logic v;
        logic s;
        logic last;
    } ent_t;

    ent_t        q[$];
    int unsigned mcnt = 0;
    int          n_cmp = 0;
    int          n_err = 0;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic push_frame(input logic [DATA_W-1:0] d);
        logic [3:0] pat;
        ent_t       e;
        pat = SYNC_PAT;
        for (int i = SYNC_W - 1; i >= 0; i--) begin
            e = '{b: pat[i], v: 1'b1, s: (i == SYNC_W - 1), last: 1'b0};
            q.push_back(e);
        end
        for (int i = DATA_W - 1; i >= 0; i--) begin
            e = '{b: d[i], v: 1'b1, s: 1'b0, last: 1'b0};
            q.push_back(e);
        end
`ifdef SEQ_GEN_PARITY_EN
        e = '{b: (^d), v: 1'b1, s: 1'b0, last: 1'b0};
        q.push_back(e);
`endif
        q[q.size() - 1].last = 1'b1;
        for (int i = 0; i < GAP_BITS; i++) begin
            e = '{b: 1'b0, v: 1'b0, s: 1'b0, last: 1'b0};
            q.push_back(e);
        end
    endtask

    task automatic check_outputs();
        ent_t e;
        e = (q.size() > 0) ? q[0] : '0;
        check_eq("out_bit",    32'(out_bit),    32'(e.b));
        check_eq("out_valid",  32'(out_valid),  32'(e.v));
        check_eq("sync_start", 32'(sync_start), 32'(e.s));
        check_eq("busy",       32'(busy),       32'(q.size() > 0));
        check_eq("frame_cnt",  32'(frame_cnt),  mcnt % (1 << CNT_W));
        check_eq("frame_cnt2", 32'(frame_cnt2), mcnt % 4);
        check_eq("out_bit2",   32'(out_bit2),   32'(e.b));
    endtask

    // Called just after an edge; drives inputs, advances the model one cycle.
    task automatic step(input logic v, input logic [DATA_W-1:0] d);
        logic exp_rdy;
        logic acc;
        ent_t e;
        in_valid = v;
        in_data  = d;
        exp_rdy  = (q.size() == 0);
        #1;
        check_eq("in_ready", 32'(in_ready), 32'(exp_rdy));
        acc = v && exp_rdy;
        @(posedge clk);
        if (q.size() > 0) begin
            e = q.pop_front();
            if (e.last) mcnt++;
        end
        if (acc) push_frame(d);
        #1;
        check_outputs();
    endtask

    task automatic drain();
        for (int i = 0; i < 40 && q.size() > 0; i++) step(1'b0, DATA_W'($urandom));
    endtask

    initial begin
        reset = 1'b0;
        #2;
        check_outputs();
        check_eq("in_ready_rst", 32'(in_ready), 32'd1);
        repeat (2) @(posedge clk);
        #3 reset = 1'b1;
        @(posedge clk);
        #1;
        check_outputs();

        // Single A5 frame with in_data scrambled while busy
        step(1'b1, 8'hA5);
        repeat (16) step(1'b0, DATA_W'($urandom));

        // Back-to-back with in_valid held; 3C offered throughout the 2nd frame
        step(1'b1, 8'h00);
        repeat (14) step(1'b1, 8'hFF);
        repeat (16) step(1'b1, 8'h3C);
        step(1'b1, 8'h07);
        drain();

        // Payload containing the preamble, and parity-sensitive words
        step(1'b1, 8'hB1);
        drain();
        step(1'b1, 8'h07);
        drain();

        // Random traffic
        for (int i = 0; i < 600; i++) begin
            step(($urandom_range(0, 3) != 0), DATA_W'($urandom));
        end
        drain();

        // Reset during the 5th payload bit
        step(1'b1, 8'hC3);
        repeat (8) step(1'b0, DATA_W'($urandom));
        check_eq("pre_rst_valid", 32'(out_valid), 32'd1);
        reset = 1'b0;
        #1;
        q.delete();
        mcnt = 0;
        check_outputs();
        check_eq("in_ready_abort", 32'(in_ready), 32'd1);
        in_valid = 1'b0;
        @(posedge clk);
        #4 reset = 1'b1;
        @(posedge clk);
        #1;
        check_outputs();
        repeat (4) step(1'b0, DATA_W'($urandom));

        // More random traffic after the abort
        for (int i = 0; i < 400; i++) begin
            step(($urandom_range(0, 1) != 0), DATA_W'($urandom));
        end
        drain();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

`default_nettype wire
